silife_step_scheduler: RTL and testbench
========================================

Name: silife_step_scheduler

Overview:
Sequences all accesses to the silife grid core's control inputs: row_select, en, wr_en, data_in and the display-enable bit. It arbitrates between a host requester (the UART command handler) and an internal autorun timer that issues periodic generation steps. It gates the MAX7219 display path while the host owns the shared output bus. It sits between the UART command logic and the grid core, in the FPGA top level.

Parameters:
ROW_W, 5, row address width (32 rows)
COL_W, 8, cells per row; width of the row data buses
PERIOD_W, 24, width of the autorun period, in clk cycles
STEP_HOLDOFF, 2, idle cycles forced after each step pulse before the next grid access (range 0..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_run  in  1  level; autorun timer enabled
cfg_period  in  PERIOD_W  autorun period in cycles; 0 is treated as 1
host_lock  in  1  level; host owns the grid output bus (dump in progress)
host_req_valid  in  1  request valid
host_req_ready  out  1  request accepted when valid && ready
host_req_op  in  2  0 = STEP, 1 = READ row, 2 = WRITE row, 3 = reserved (accepted, no-op)
host_req_row  in  ROW_W  target row
host_req_wdata  in  COL_W  row data for WRITE
host_rsp_valid  out  1  one-cycle pulse; READ data valid
host_rsp_rdata  out  COL_W  captured row data
grid_row_select  out  ROW_W  to core
grid_en  out  1  one-cycle step pulse to core
grid_wr_en  out  1  one-cycle row write strobe to core
grid_data_in  out  COL_W  to core
grid_data_out  in  COL_W  from core, for the selected row
grid_display_en  out  1  MAX7219 enable to core
gen_count  out  16  generations stepped; wraps at 0xFFFF -> 0
overrun_count  out  8  autorun ticks dropped (see Optional Feature)

Behaviour:
- Reset: all outputs 0, except grid_display_en = 1 and host_req_ready = 1. FSM in IDLE. Pending tick cleared, timer counter = 0, in-flight response discarded.
- All outputs are registered.
- FSM states: IDLE, STEP, HOLD, WRITE, READ_ADDR, READ_CAP.
- Timer:
  - Counts while cfg_run && !host_lock.
  - At count >= max(cfg_period,1)-1: the counter reloads to 0 and sets tick_pending.
  - Lowering cfg_period below the current count causes a tick on the next counting cycle.
  - cfg_run = 0 freezes the count and keeps any pending tick. host_lock = 1 also freezes the count.
- tick_pending is a single bit. A tick that arrives while it is already set is dropped and counted.
- IDLE arbitration: a host request wins over tick_pending. A tick is serviced only when host_lock = 0.
- host_req_ready = 1 only in IDLE; it is 0 in all other states.
- STEP:
  - Entered from an accepted host STEP or a serviced tick. A serviced tick clears tick_pending.
  - grid_en = 1 for exactly one cycle and gen_count increments.
  - Then HOLD for STEP_HOLDOFF cycles, then IDLE. With STEP_HOLDOFF = 0, go straight to IDLE.
- WRITE:
  - On accept edge E0, latch the row and wdata onto grid_row_select and grid_data_in.
  - grid_wr_en = 1 during the single cycle after E0, then IDLE.
  - grid_row_select and grid_data_in hold their values until the next access.
- READ:
  - After accept edge E0, state is READ_ADDR with grid_row_select = row.
  - At E1, go to READ_CAP.
  - At E2, capture grid_data_out into host_rsp_rdata; host_rsp_valid pulses during the cycle after E2.
  - Latency from accept to rsp_valid is 2 cycles. rsp_rdata holds until the next READ.
- grid_display_en = !(host_lock || state in {READ_ADDR, READ_CAP}).
- Op 3 is accepted and returns to IDLE on the next cycle. It produces no grid strobe and no response.
- grid_en and grid_wr_en are never high in the same cycle.
- The host may drive host_lock without issuing requests; this suppresses stepping only.

Optional Feature:
SILIFE_SCHED_STATS_EN
- Defined: overrun_count increments, saturating at 255, on each dropped tick. Setting cfg_run from 0 to 1 clears it.
- Undefined: overrun_count is tied to 0 and its counter logic is not built. Ticks are still dropped identically.

Decomposition:
- Package silife_sched_pkg holds the op encodings (OP_STEP, OP_READ, OP_WRITE, OP_NOP), the FSM state enum, and ROW_W/COL_W defaults.
- One sub-module, silife_step_timer, contains the period counter, reload, freeze and tick_pending generation. Its ports are clk, rst, run, hold, period, tick_ack, tick_pending and tick_drop.

Test Plan:
1. Reset, then host WRITE row 5 with wdata 0xA5 -> grid_wr_en high exactly one cycle with grid_row_select = 5 and grid_data_in = 0xA5. host_req_ready returns to 1 on the next cycle.
2. Host READ row 31 while the model drives grid_data_out = 0x3C for row 31 -> host_rsp_valid pulses 2 cycles after accept with rdata 0x3C. grid_display_en = 0 during READ_ADDR and READ_CAP.
3. cfg_run = 1, cfg_period = 10, STEP_HOLDOFF = 2, for 100 cycles -> grid_en pulses every 10 cycles; gen_count = 10.
4. Host READ requests held back-to-back while a tick is pending -> the host wins each IDLE arbitration. The tick is stepped once the host goes idle; only one step results.
5. host_lock = 1 for 50 cycles with cfg_run = 1 and cfg_period = 4 -> no grid_en, grid_display_en = 0, timer frozen. Steps resume after release.
6. With SILIFE_SCHED_STATS_EN, cfg_period = 1 and continuous host READs for 20 cycles -> overrun_count > 0. A cfg_run toggle clears it. Reset mid-READ -> no rsp_valid.

Source files
------------

// File: rtl/silife_sched_pkg.sv
// Shared encodings for the silife step scheduler: host op codes, FSM states, default widths.
package silife_sched_pkg;

  localparam int unsigned DEF_ROW_W = 5;
  localparam int unsigned DEF_COL_W = 8;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned HOLD_W    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_STEP  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_NOP   = 2'd3
  } host_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STEP      = 3'd1,
    ST_HOLD      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ_ADDR = 3'd4,
    ST_READ_CAP  = 3'd5
  } sched_state_e;

endpackage

// File: rtl/silife_step_timer.sv
// Autorun period counter: counts while run && !hold, raises a single-bit pending tick
// on each period wrap and pulses tick_drop when a wrap finds a tick still pending.
module silife_step_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                hold,
  input  logic [PERIOD_W-1:0] period,
  input  logic                tick_ack,
  output logic                tick_pending,
  output logic                tick_drop
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] limit;
  logic                counting;
  logic                wrap;

  // A zero period behaves as a period of one; >= makes a lowered period tick promptly.
  always_comb begin
    limit    = (period == '0) ? '0 : period - PERIOD_W'(1);
    counting = run && !hold;
    wrap     = counting && (count >= limit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      tick_pending <= 1'b0;
      tick_drop    <= 1'b0;
    end else begin
      tick_drop <= 1'b0;
      if (counting) begin
        count <= wrap ? '0 : count + PERIOD_W'(1);
      end
      if (wrap) begin
        if (tick_pending && !tick_ack) begin
          tick_drop <= 1'b1;
        end else begin
          tick_pending <= 1'b1;
        end
      end else if (tick_ack) begin
        tick_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/silife_step_scheduler.sv
// Arbitrates host row accesses and autorun steps onto the silife grid core controls.
// Optional build macro SILIFE_SCHED_STATS_EN enables the saturating overrun counter.
module silife_step_scheduler
  import silife_sched_pkg::*;
#(
  parameter int unsigned ROW_W        = DEF_ROW_W,
  parameter int unsigned COL_W        = DEF_COL_W,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned STEP_HOLDOFF = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_run,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                host_lock,
  input  logic                host_req_valid,
  output logic                host_req_ready,
  input  logic [OP_W-1:0]     host_req_op,
  input  logic [ROW_W-1:0]    host_req_row,
  input  logic [COL_W-1:0]    host_req_wdata,
  output logic                host_rsp_valid,
  output logic [COL_W-1:0]    host_rsp_rdata,
  output logic [ROW_W-1:0]    grid_row_select,
  output logic                grid_en,
  output logic                grid_wr_en,
  output logic [COL_W-1:0]    grid_data_in,
  input  logic [COL_W-1:0]    grid_data_out,
  output logic                grid_display_en,
  output logic [15:0]         gen_count,
  output logic [7:0]          overrun_count
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((STEP_HOLDOFF == 0) ? 0 : STEP_HOLDOFF - 1);

  sched_state_e      state;
  sched_state_e      state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept_c;
  logic              tick_ack_c;
  logic              tick_pending;
  logic              tick_drop;
  host_op_e          req_op;

  silife_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .run          (cfg_run),
    .hold         (host_lock),
    .period       (cfg_period),
    .tick_ack     (tick_ack_c),
    .tick_pending (tick_pending),
    .tick_drop    (tick_drop)
  );

  // Next-state and arbitration: a host request always beats a pending tick.
  always_comb begin
    req_op     = host_op_e'(host_req_op);
    accept_c   = 1'b0;
    tick_ack_c = 1'b0;
    state_nxt  = state;
    unique case (state)
      ST_IDLE: begin
        if (host_req_valid && host_req_ready) begin
          accept_c = 1'b1;
          unique case (req_op)
            OP_STEP:  state_nxt = ST_STEP;
            OP_READ:  state_nxt = ST_READ_ADDR;
            OP_WRITE: state_nxt = ST_WRITE;
            OP_NOP:   state_nxt = ST_HOLD;
          endcase
        end else if (tick_pending && !host_lock) begin
          tick_ack_c = 1'b1;
          state_nxt  = ST_STEP;
        end
      end
      ST_STEP:      state_nxt = (STEP_HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD:      state_nxt = (hold_cnt == '0) ? ST_IDLE : ST_HOLD;
      ST_WRITE:     state_nxt = ST_IDLE;
      ST_READ_ADDR: state_nxt = ST_READ_CAP;
      ST_READ_CAP:  state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered grid/host outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      hold_cnt        <= '0;
      host_req_ready  <= 1'b1;
      host_rsp_valid  <= 1'b0;
      host_rsp_rdata  <= '0;
      grid_row_select <= '0;
      grid_en         <= 1'b0;
      grid_wr_en      <= 1'b0;
      grid_data_in    <= '0;
      grid_display_en <= 1'b1;
      gen_count       <= '0;
    end else begin
      state           <= state_nxt;
      host_req_ready  <= (state_nxt == ST_IDLE);
      grid_en         <= (state_nxt == ST_STEP);
      grid_wr_en      <= (state_nxt == ST_WRITE);
      grid_display_en <= !(host_lock || state_nxt == ST_READ_ADDR ||
                           state_nxt == ST_READ_CAP);
      host_rsp_valid  <= (state == ST_READ_CAP);

      if (state == ST_READ_CAP) begin
        host_rsp_rdata <= grid_data_out;
      end
      if (state_nxt == ST_STEP) begin
        gen_count <= gen_count + 16'd1;
      end

      if (accept_c && (req_op == OP_WRITE || req_op == OP_READ)) begin
        grid_row_select <= host_req_row;
      end
      if (accept_c && req_op == OP_WRITE) begin
        grid_data_in <= host_req_wdata;
      end

      // Steps load the holdoff; a NOP passes through HOLD for a single cycle.
      if (state_nxt == ST_HOLD && state != ST_HOLD) begin
        hold_cnt <= (state == ST_STEP) ? HOLD_LOAD : '0;
      end else if (state == ST_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

`ifdef SILIFE_SCHED_STATS_EN
  logic run_q;

  // Saturating count of dropped ticks, cleared when autorun is re-enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q         <= 1'b0;
      overrun_count <= '0;
    end else begin
      run_q <= cfg_run;
      if (cfg_run && !run_q) begin
        overrun_count <= '0;
      end else if (tick_drop && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end
`else
  logic unused_tick_drop;
  assign unused_tick_drop = tick_drop;
  assign overrun_count    = '0;
`endif

endmodule

// File: tb/tb_silife_step_scheduler.sv
// Directed self-checking bench for silife_step_scheduler (default parameters, STEP_HOLDOFF = 2).
module tb_silife_step_scheduler;

  localparam int unsigned ROW_W    = 5;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned PERIOD_W = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_run;
  logic [PERIOD_W-1:0] cfg_period;
  logic                host_lock;
  logic                host_req_valid;
  logic                host_req_ready;
  logic [1:0]          host_req_op;
  logic [ROW_W-1:0]    host_req_row;
  logic [COL_W-1:0]    host_req_wdata;
  logic                host_rsp_valid;
  logic [COL_W-1:0]    host_rsp_rdata;
  logic [ROW_W-1:0]    grid_row_select;
  logic                grid_en;
  logic                grid_wr_en;
  logic [COL_W-1:0]    grid_data_in;
  logic [COL_W-1:0]    grid_data_out;
  logic                grid_display_en;
  logic [15:0]         gen_count;
  logic [7:0]          overrun_count;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_gen;

  always #5 clk = ~clk;

  // Grid core stand-in: row 31 holds 0x3C, every other row holds row ^ 0x5A.
  assign grid_data_out = (grid_row_select == 5'd31) ? 8'h3C : (8'(grid_row_select) ^ 8'h5A);

  silife_step_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_run         (cfg_run),
    .cfg_period      (cfg_period),
    .host_lock       (host_lock),
    .host_req_valid  (host_req_valid),
    .host_req_ready  (host_req_ready),
    .host_req_op     (host_req_op),
    .host_req_row    (host_req_row),
    .host_req_wdata  (host_req_wdata),
    .host_rsp_valid  (host_rsp_valid),
    .host_rsp_rdata  (host_rsp_rdata),
    .grid_row_select (grid_row_select),
    .grid_en         (grid_en),
    .grid_wr_en      (grid_wr_en),
    .grid_data_in    (grid_data_in),
    .grid_data_out   (grid_data_out),
    .grid_display_en (grid_display_en),
    .gen_count       (gen_count),
    .overrun_count   (overrun_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_run = 1'b0; cfg_period = '0; host_lock = 1'b0;
    host_req_valid = 1'b0; host_req_op = 2'd0; host_req_row = '0; host_req_wdata = '0;
    tick1(); tick1();
    rst = 1'b0;
    exp_gen = 16'd0;
  endtask

  // Presents a request, waits for ready, and returns at accept edge + 1.
  task automatic host_issue(input logic [1:0] op, input logic [4:0] row, input logic [7:0] wd);
    int n;
    n = 0;
    host_req_op = op; host_req_row = row; host_req_wdata = wd; host_req_valid = 1'b1;
    while (!host_req_ready && n < 50) begin
      tick1();
      n++;
    end
    if (n == 50) begin
      compared++; mismatched++;
      $display("FAIL issue_timeout: ready=%0b required 1", host_req_ready);
    end
    tick1();
    host_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_run = 1'b0; cfg_period = '0; host_lock = 1'b0;
    host_req_valid = 1'b0; host_req_op = 2'd0; host_req_row = '0; host_req_wdata = '0;
    tick1(); tick1();
    compared++;
    if (host_req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %0b want 1", host_req_ready); end
    compared++;
    if (grid_display_en !== 1'b1) begin mismatched++; $display("FAIL reset_display: got %0b want 1", grid_display_en); end
    compared++;
    if ({grid_en, grid_wr_en, host_rsp_valid} !== 3'b000) begin
      mismatched++; $display("FAIL reset_strobes: got %b want 000", {grid_en, grid_wr_en, host_rsp_valid});
    end
    compared++;
    if (gen_count !== 16'd0 || overrun_count !== 8'd0) begin
      mismatched++; $display("FAIL reset_counts: gen=%0d ovr=%0d want 0/0", gen_count, overrun_count);
    end
    compared++;
    if (grid_row_select !== 5'd0 || grid_data_in !== 8'd0 || host_rsp_rdata !== 8'd0) begin
      mismatched++; $display("FAIL reset_buses: row=%0d din=%h rd=%h want 0", grid_row_select, grid_data_in, host_rsp_rdata);
    end
    rst = 1'b0;
    exp_gen = 16'd0;
  endtask

  task automatic test_write();
    compared++;
    if (grid_wr_en !== 1'b0) begin mismatched++; $display("FAIL wr_pre: wr_en=%0b want 0", grid_wr_en); end
    host_issue(2'd2, 5'd5, 8'hA5);
    compared++;
    if (grid_wr_en !== 1'b1 || grid_en !== 1'b0) begin
      mismatched++; $display("FAIL wr_strobe: wr_en=%0b en=%0b want 1/0", grid_wr_en, grid_en);
    end
    compared++;
    if (grid_row_select !== 5'd5 || grid_data_in !== 8'hA5) begin
      mismatched++; $display("FAIL wr_bus: row=%0d din=%h want 5/a5", grid_row_select, grid_data_in);
    end
    compared++;
    if (host_req_ready !== 1'b0) begin mismatched++; $display("FAIL wr_busy: ready=%0b want 0", host_req_ready); end
    tick1();
    compared++;
    if (grid_wr_en !== 1'b0 || host_req_ready !== 1'b1) begin
      mismatched++; $display("FAIL wr_done: wr_en=%0b ready=%0b want 0/1", grid_wr_en, host_req_ready);
    end
    compared++;
    if (grid_row_select !== 5'd5 || grid_data_in !== 8'hA5) begin
      mismatched++; $display("FAIL wr_hold: row=%0d din=%h want 5/a5", grid_row_select, grid_data_in);
    end
  endtask

  task automatic test_read();
    host_issue(2'd1, 5'd31, 8'h00);
    compared++;
    if (grid_display_en !== 1'b0 || grid_row_select !== 5'd31 || host_rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL rd_addr: disp=%0b row=%0d rv=%0b want 0/31/0", grid_display_en, grid_row_select, host_rsp_valid);
    end
    compared++;
    if (grid_data_in !== 8'hA5) begin mismatched++; $display("FAIL rd_din_hold: din=%h want a5", grid_data_in); end
    tick1();
    compared++;
    if (grid_display_en !== 1'b0 || host_rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL rd_cap: disp=%0b rv=%0b want 0/0", grid_display_en, host_rsp_valid);
    end
    tick1();
    compared++;
    if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== 8'h3C) begin
      mismatched++; $display("FAIL rd_rsp: rv=%0b rd=%h want 1/3c", host_rsp_valid, host_rsp_rdata);
    end
    compared++;
    if (grid_display_en !== 1'b1 || host_req_ready !== 1'b1) begin
      mismatched++; $display("FAIL rd_release: disp=%0b ready=%0b want 1/1", grid_display_en, host_req_ready);
    end
    tick1();
    compared++;
    if (host_rsp_valid !== 1'b0 || host_rsp_rdata !== 8'h3C) begin
      mismatched++; $display("FAIL rd_after: rv=%0b rd=%h want 0/3c", host_rsp_valid, host_rsp_rdata);
    end
  endtask

  task automatic test_step_nop();
    host_issue(2'd0, 5'd0, 8'h00);
    exp_gen = exp_gen + 16'd1;
    compared++;
    if (grid_en !== 1'b1 || grid_wr_en !== 1'b0 || gen_count !== exp_gen) begin
      mismatched++; $display("FAIL step_pulse: en=%0b wr=%0b gen=%0d want 1/0/%0d", grid_en, grid_wr_en, gen_count, exp_gen);
    end
    tick1();
    compared++;
    if (grid_en !== 1'b0 || host_req_ready !== 1'b0) begin
      mismatched++; $display("FAIL step_hold1: en=%0b ready=%0b want 0/0", grid_en, host_req_ready);
    end
    tick1();
    compared++;
    if (host_req_ready !== 1'b0) begin mismatched++; $display("FAIL step_hold2: ready=%0b want 0", host_req_ready); end
    tick1();
    compared++;
    if (host_req_ready !== 1'b1) begin mismatched++; $display("FAIL step_idle: ready=%0b want 1", host_req_ready); end
    host_issue(2'd3, 5'd9, 8'hFF);
    compared++;
    if (host_req_ready !== 1'b0 || {grid_en, grid_wr_en, host_rsp_valid} !== 3'b000) begin
      mismatched++; $display("FAIL nop_busy: ready=%0b strobes=%b want 0/000", host_req_ready, {grid_en, grid_wr_en, host_rsp_valid});
    end
    tick1();
    compared++;
    if (host_req_ready !== 1'b1 || host_rsp_valid !== 1'b0 || gen_count !== exp_gen || grid_data_in !== 8'hA5) begin
      mismatched++; $display("FAIL nop_done: ready=%0b rv=%0b gen=%0d din=%h want 1/0/%0d/a5", host_req_ready, host_rsp_valid, gen_count, exp_gen, grid_data_in);
    end
  endtask

  task automatic test_autorun();
    int pulses;
    int bad_phase;
    do_reset();
    cfg_period = 24'd10;
    cfg_run = 1'b1;
    pulses = 0; bad_phase = 0;
    for (int i = 1; i <= 110; i++) begin
      tick1();
      if (i == 100) cfg_run = 1'b0;
      if (grid_en) begin
        pulses++;
        if (i % 10 != 1 || i < 11) bad_phase++;
      end
    end
    compared++;
    if (pulses !== 10) begin mismatched++; $display("FAIL auto_pulses: got %0d want 10", pulses); end
    compared++;
    if (bad_phase !== 0) begin mismatched++; $display("FAIL auto_spacing: off-phase pulses %0d want 0", bad_phase); end
    compared++;
    if (gen_count !== 16'd10) begin mismatched++; $display("FAIL auto_gen: got %0d want 10", gen_count); end
  endtask

  task automatic test_back_to_back();
    int rsps;
    int bad_data;
    int steps;
    do_reset();
    host_req_op = 2'd1; host_req_row = 5'd7; host_req_valid = 1'b1;
    cfg_period = 24'd2;
    cfg_run = 1'b1;
    rsps = 0; bad_data = 0; steps = 0;
    for (int i = 1; i <= 15; i++) begin
      tick1();
      if (i == 2) cfg_run = 1'b0;
      if (grid_en) steps++;
      if (host_rsp_valid) begin
        rsps++;
        if (host_rsp_rdata !== 8'h5D) bad_data++;
      end
    end
    host_req_valid = 1'b0;
    compared++;
    if (steps !== 0) begin mismatched++; $display("FAIL b2b_host_wins: steps=%0d want 0", steps); end
    compared++;
    if (rsps !== 5 || bad_data !== 0) begin
      mismatched++; $display("FAIL b2b_rsps: rsps=%0d bad=%0d want 5/0", rsps, bad_data);
    end
    for (int i = 0; i < 12; i++) begin
      tick1();
      if (grid_en) steps++;
    end
    compared++;
    if (steps !== 1 || gen_count !== 16'd1) begin
      mismatched++; $display("FAIL b2b_tick_once: steps=%0d gen=%0d want 1/1", steps, gen_count);
    end
  endtask

  task automatic test_host_lock();
    int bad_en;
    int bad_disp;
    int first_step;
    do_reset();
    host_lock = 1'b1;
    cfg_period = 24'd4;
    cfg_run = 1'b1;
    bad_en = 0; bad_disp = 0;
    for (int i = 1; i <= 50; i++) begin
      tick1();
      if (grid_en) bad_en++;
      if (grid_display_en) bad_disp++;
    end
    compared++;
    if (bad_en !== 0 || gen_count !== 16'd0) begin
      mismatched++; $display("FAIL lock_no_step: pulses=%0d gen=%0d want 0/0", bad_en, gen_count);
    end
    compared++;
    if (bad_disp !== 0) begin mismatched++; $display("FAIL lock_display: enabled cycles=%0d want 0", bad_disp); end
    host_lock = 1'b0;
    first_step = 0;
    for (int j = 1; j <= 12; j++) begin
      tick1();
      if (grid_en && first_step == 0) first_step = j;
    end
    cfg_run = 1'b0;
    compared++;
    if (first_step !== 5) begin mismatched++; $display("FAIL lock_resume: first step at %0d want 5", first_step); end
    compared++;
    if (grid_display_en !== 1'b1) begin mismatched++; $display("FAIL lock_release_disp: got %0b want 1", grid_display_en); end
  endtask

  task automatic test_overrun_and_reset();
    int rv_seen;
    do_reset();
    host_req_op = 2'd1; host_req_row = 5'd2; host_req_valid = 1'b1;
    cfg_period = 24'd1;
    cfg_run = 1'b1;
    for (int i = 1; i <= 20; i++) tick1();
    host_req_valid = 1'b0;
    cfg_run = 1'b0;
    for (int i = 0; i < 8; i++) tick1();
    compared++;
`ifdef SILIFE_SCHED_STATS_EN
    if (!(overrun_count > 8'd0)) begin mismatched++; $display("FAIL ovr_count: got %0d want >0", overrun_count); end
`else
    if (overrun_count !== 8'd0) begin mismatched++; $display("FAIL ovr_tied: got %0d want 0", overrun_count); end
`endif
    cfg_run = 1'b1;
    tick1();
    cfg_run = 1'b0;
    compared++;
    if (overrun_count !== 8'd0) begin mismatched++; $display("FAIL ovr_clear: got %0d want 0", overrun_count); end
    for (int i = 0; i < 6; i++) tick1();
    compared++;
    if (overrun_count !== 8'd0) begin mismatched++; $display("FAIL ovr_stay: got %0d want 0", overrun_count); end
    host_issue(2'd1, 5'd3, 8'h00);
    rst = 1'b1;
    tick1(); tick1();
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick1();
      if (host_rsp_valid) rv_seen++;
    end
    compared++;
    if (rv_seen !== 0 || host_req_ready !== 1'b1) begin
      mismatched++; $display("FAIL rst_mid_read: rsp pulses=%0d ready=%0b want 0/1", rv_seen, host_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_step_nop();
    test_autorun();
    test_back_to_back();
    test_host_lock();
    test_overrun_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
